// File: rtl/servo_pwm_gen.sv
// Servo PWM output stage: fixed-period frame, clamped width latched at frame boundaries.
// Optional macro SERVO_PWM_SLEW_EN limits the ACTIVE_WIDTH change per frame to SLEW_STEP.
module servo_pwm_gen #(
    parameter int PERIOD    = 1000000,
    parameter int MIN_WIDTH = 50000,
    parameter int MAX_WIDTH = 100000,
    parameter int SLEW_STEP = 500
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [16:0] WIDTH,
    input  logic        ENABLE,
    output logic        PWM,
    output logic        FRAME_START,
    output logic [16:0] ACTIVE_WIDTH,
    output logic        CLAMPED
);

    localparam logic [19:0] CNT_LAST = 20'(PERIOD - 1);
    localparam logic [16:0] W_MIN    = 17'(MIN_WIDTH);
    localparam logic [16:0] W_MAX    = 17'(MAX_WIDTH);
`ifdef SERVO_PWM_SLEW_EN
    localparam logic [16:0] W_STEP   = 17'(SLEW_STEP);
`endif

    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic        en_q;
    logic        en_nxt;
    logic [16:0] tgt;
    logic [16:0] aw_nxt;
    logic        boundary;
    logic        out_of_range;

    always_comb begin
        boundary     = (cnt == CNT_LAST);
        out_of_range = (WIDTH < W_MIN) || (WIDTH > W_MAX);
        if (WIDTH < W_MIN)
            tgt = W_MIN;
        else if (WIDTH > W_MAX)
            tgt = W_MAX;
        else
            tgt = WIDTH;

        cnt_nxt = boundary ? 20'd0 : cnt + 20'd1;
        en_nxt  = boundary ? ENABLE : en_q;
        aw_nxt  = ACTIVE_WIDTH;
        if (boundary) begin
`ifdef SERVO_PWM_SLEW_EN
            // Step only when the gap exceeds SLEW_STEP, so the result never passes tgt or wraps.
            if (tgt > ACTIVE_WIDTH)
                aw_nxt = ((tgt - ACTIVE_WIDTH) <= W_STEP) ? tgt : ACTIVE_WIDTH + W_STEP;
            else
                aw_nxt = ((ACTIVE_WIDTH - tgt) <= W_STEP) ? tgt : ACTIVE_WIDTH - W_STEP;
`else
            aw_nxt = tgt;
`endif
        end
    end

    // PWM is computed from next-state values so it lines up with cnt in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt          <= CNT_LAST;
            en_q         <= 1'b0;
            ACTIVE_WIDTH <= W_MIN;
            CLAMPED      <= 1'b0;
            FRAME_START  <= 1'b0;
            PWM          <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            en_q         <= en_nxt;
            ACTIVE_WIDTH <= aw_nxt;
            FRAME_START  <= boundary;
            if (boundary)
                CLAMPED <= out_of_range;
            PWM          <= en_nxt && (cnt_nxt < {3'b000, aw_nxt});
        end
    end

endmodule
